// File: rtl/punc_debug_dumper.sv
// punc_debug_dumper: walks the PUnC debug port and streams a machine-state
// snapshot (R0..R7, PC, then mem_count words from mem_base) over valid/ready.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start; mem_base/mem_count captured on start
// RF_SET   | rf_debug_addr presents reg_idx (samples here if READ_LAT=0)
// RF_WAIT  | counting down READ_LAT-1..0, samples rf_debug_data at 0
// RF_EMIT  | register word offered; advances reg_idx on handshake
// PC_EMIT  | PC word offered (sampled on entry, no address phase)
// MEM_SET  | mem_debug_addr presents pointer (samples here if READ_LAT=0)
// MEM_WAIT | counting down READ_LAT-1..0, samples mem_debug_data at 0
// MEM_EMIT | memory word offered; advances pointer/count on handshake
// FINISH   | one-cycle done pulse, then back to IDLE
module punc_debug_dumper #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] mem_base,
  input  logic [15:0] mem_count,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_debug_addr,
  output logic [15:0] mem_debug_addr,
  input  logic [15:0] rf_debug_data,
  input  logic [15:0] pc_debug_data,
  input  logic [15:0] mem_debug_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_kind,
  output logic [15:0] out_index,
  output logic [15:0] out_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RF_SET,
    S_RF_WAIT,
    S_RF_EMIT,
    S_PC_EMIT,
    S_MEM_SET,
    S_MEM_WAIT,
    S_MEM_EMIT,
    S_FINISH
  } state_e;

  localparam bit         NO_WAIT   = (READ_LAT == 0);
  localparam logic [2:0] WAIT_INIT = 3'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  state_e      state_q, state_d;
  logic [2:0]  reg_idx_q, reg_idx_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  wait_q, wait_d;
  logic [15:0] data_q, data_d;
  logic [2:0]  rf_addr_q, rf_addr_d;
  logic [15:0] mem_addr_q, mem_addr_d;

  assign busy           = (state_q != S_IDLE);
  assign out_data       = data_q;
  assign rf_debug_addr  = rf_addr_q;
  assign mem_debug_addr = mem_addr_q;

  // State and datapath registers; reset abandons any snapshot in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      reg_idx_q  <= 3'd0;
      ptr_q      <= 16'd0;
      cnt_q      <= 16'd0;
      wait_q     <= 3'd0;
      data_q     <= 16'd0;
      rf_addr_q  <= 3'd0;
      mem_addr_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
      rf_addr_q  <= rf_addr_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next-state and output decode. Debug addresses are loaded on the
  // transition into a SET state so they are already valid during SET,
  // which lets READ_LAT=0 sample in that same cycle.
  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    data_d     = data_q;
    rf_addr_d  = rf_addr_q;
    mem_addr_d = mem_addr_q;
    out_valid  = 1'b0;
    out_kind   = 2'd0;
    out_index  = 16'd0;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d     = mem_base;
          cnt_d     = mem_count;
          reg_idx_d = 3'd0;
          rf_addr_d = 3'd0;
          state_d   = S_RF_SET;
        end
      end
      S_RF_SET: begin
        if (NO_WAIT) begin
          data_d  = rf_debug_data;
          state_d = S_RF_EMIT;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = S_RF_WAIT;
        end
      end
      S_RF_WAIT: begin
        if (wait_q == 3'd0) begin
          data_d  = rf_debug_data;
          state_d = S_RF_EMIT;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_RF_EMIT: begin
        out_valid = 1'b1;
        out_kind  = 2'd0;
        out_index = {13'd0, reg_idx_q};
        if (out_ready) begin
          if (reg_idx_q == 3'd7) begin
            data_d  = pc_debug_data;
            state_d = S_PC_EMIT;
          end else begin
            reg_idx_d = reg_idx_q + 3'd1;
            rf_addr_d = reg_idx_q + 3'd1;
            state_d   = S_RF_SET;
          end
        end
      end
      S_PC_EMIT: begin
        out_valid = 1'b1;
        out_kind  = 2'd1;
        out_index = 16'd0;
        if (out_ready) begin
          if (cnt_q == 16'd0) begin
            state_d = S_FINISH;
          end else begin
            mem_addr_d = ptr_q;
            state_d    = S_MEM_SET;
          end
        end
      end
      S_MEM_SET: begin
        if (NO_WAIT) begin
          data_d  = mem_debug_data;
          state_d = S_MEM_EMIT;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (wait_q == 3'd0) begin
          data_d  = mem_debug_data;
          state_d = S_MEM_EMIT;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_MEM_EMIT: begin
        out_valid = 1'b1;
        out_kind  = 2'd2;
        out_index = ptr_q;
        if (out_ready) begin
          ptr_d = ptr_q + 16'd1;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = S_FINISH;
          end else begin
            mem_addr_d = ptr_q + 16'd1;
            state_d    = S_MEM_SET;
          end
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Bench for punc_debug_dumper: three instances (READ_LAT 1, 0, 3) share one
// machine model; each snapshot's word list is queued at start and checked by
// a per-instance monitor as words are accepted.
module tb_punc_debug_dumper;

  localparam int NI = 3;

  typedef struct packed {
    logic        first;
    logic [1:0]  kind;
    logic [15:0] index;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] mem_base, mem_count;
  logic        start_v [NI];
  int          rmode   [NI];
  logic        rdy_man [NI];
  logic        active  [NI];
  logic        tight   [NI];
  exp_t        exp_q   [NI][$];

  logic [15:0] rf_vals [0:7];
  logic [15:0] pc_val;
  logic [15:0] mem [0:65535];

  int n_tests, n_fail;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int g, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", name, g, act, exp, $time);
    end
  endtask

  task automatic fail_now(string name, int g);
    n_tests++;
    n_fail++;
    $display("FAIL %s inst%0d: condition not reached (t=%0t)", name, g, $time);
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int LI  = (LAT == 0) ? 0 : LAT - 1;

    logic        busy, done, out_valid, out_ready;
    logic [2:0]  rf_debug_addr;
    logic [15:0] mem_debug_addr, rf_debug_data, pc_debug_data, mem_debug_data;
    logic [1:0]  out_kind;
    logic [15:0] out_index, out_data;
    logic [2:0]  rfh [0:7];
    logic [15:0] mh  [0:7];
    logic [15:0] noise = 16'h0;
    logic [2:0]  rf_eff;
    logic [15:0] mem_eff;

    punc_debug_dumper #(.READ_LAT(LAT)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start_v[g]),
      .mem_base       (mem_base),
      .mem_count      (mem_count),
      .busy           (busy),
      .done           (done),
      .rf_debug_addr  (rf_debug_addr),
      .mem_debug_addr (mem_debug_addr),
      .rf_debug_data  (rf_debug_data),
      .pc_debug_data  (pc_debug_data),
      .mem_debug_data (mem_debug_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_kind       (out_kind),
      .out_index      (out_index),
      .out_data       (out_data)
    );

    // Debug port model: data reflects the address presented LAT cycles ago;
    // garbage is mixed in while a word is being offered (no sampling then).
    always @(posedge clk) begin
      rfh[0] <= rf_debug_addr;
      mh[0]  <= mem_debug_addr;
      for (int k = 1; k < 8; k++) begin
        rfh[k] <= rfh[k-1];
        mh[k]  <= mh[k-1];
      end
    end
    assign rf_eff         = (LAT == 0) ? rf_debug_addr : rfh[LI];
    assign mem_eff        = (LAT == 0) ? mem_debug_addr : mh[LI];
    assign rf_debug_data  = rf_vals[rf_eff] ^ (out_valid ? noise : 16'h0);
    assign mem_debug_data = mem[mem_eff] ^ (out_valid ? noise : 16'h0);
    assign pc_debug_data  = pc_val;

    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        noise = 16'($urandom);
        case (rmode[g])
          0:       out_ready = 1'b1;
          1:       out_ready = ($urandom_range(0, 3) != 0);
          default: out_ready = rdy_man[g];
        endcase
      end
    end

    initial begin
      exp_t        e;
      logic        hold;
      logic [1:0]  hk;
      logic [15:0] hi, hd;
      int          last_hs;
      hold    = 1'b0;
      last_hs = 0;
      hk = 2'd0; hi = 16'd0; hd = 16'd0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          hold = 1'b0;
        end else begin
          check("busy", g, 64'(busy), 64'(active[g]));
          if (out_valid) check("valid_outside_snapshot", g, 64'(busy), 64'd1);
          if (hold)
            check("hold_stable", g, 64'({out_valid, out_kind, out_index, out_data}),
                  64'({1'b1, hk, hi, hd}));
          hold = out_valid && !out_ready;
          hk = out_kind; hi = out_index; hd = out_data;
          if (out_valid && out_ready) begin
            if (exp_q[g].size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL extra_word inst%0d: got kind %0d index %h data %h, none expected",
                       g, out_kind, out_index, out_data);
            end else begin
              e = exp_q[g].pop_front();
              check("word", g, 64'({out_kind, out_index, out_data}),
                    64'({e.kind, e.index, e.data}));
              if (tight[g] && !e.first)
                check("spacing", g, 64'(cyc - last_hs), 64'((e.kind == 2'd1) ? 1 : LAT + 2));
            end
            last_hs = cyc;
          end
          if (done) begin
            check("done_in_snapshot", g, 64'(active[g]), 64'd1);
            check("done_words_left", g, 64'(exp_q[g].size()), 64'd0);
            check("done_latency", g, 64'(cyc - last_hs), 64'd1);
            active[g] = 1'b0;
          end
        end
      end
    end
  end

  function automatic logic [63:0] outs0();
    return 64'({g_i[0].busy, g_i[0].done, g_i[0].out_valid, g_i[0].out_kind,
                g_i[0].out_index, g_i[0].out_data, g_i[0].rf_debug_addr,
                g_i[0].mem_debug_addr});
  endfunction

  task automatic rand_regs();
    for (int r = 0; r < 8; r++) rf_vals[r] = 16'($urandom);
    pc_val = 16'($urandom);
  endtask

  task automatic rand_mem(logic [15:0] base, logic [15:0] cnt);
    for (int k = 0; k < int'(cnt); k++) mem[base + 16'(k)] = 16'($urandom);
  endtask

  task automatic do_snap(int g, logic [15:0] base, logic [15:0] cnt, logic tgt);
    exp_t e;
    @(posedge clk);
    #1;
    mem_base  = base;
    mem_count = cnt;
    tight[g]  = tgt;
    for (int r = 0; r < 8; r++) begin
      e.first = (r == 0); e.kind = 2'd0; e.index = 16'(r); e.data = rf_vals[r];
      exp_q[g].push_back(e);
    end
    e.first = 1'b0; e.kind = 2'd1; e.index = 16'd0; e.data = pc_val;
    exp_q[g].push_back(e);
    for (int k = 0; k < int'(cnt); k++) begin
      e.kind = 2'd2; e.index = base + 16'(k); e.data = mem[base + 16'(k)];
      exp_q[g].push_back(e);
    end
    start_v[g] = 1'b1;
    @(posedge clk);
    #1;
    start_v[g] = 1'b0;
    active[g]  = 1'b1;
  endtask

  task automatic wait_done(int g, int budget);
    int n = 0;
    while (active[g] && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (active[g]) begin
      fail_now("snapshot_timeout", g);
      active[g] = 1'b0;
      exp_q[g].delete();
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    int n;
    logic [15:0] b, c;
    int g;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    mem_base = 16'd0;
    mem_count = 16'd0;
    pc_val = 16'd0;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; rmode[i] = 0; rdy_man[i] = 1'b1;
      active[i] = 1'b0; tight[i] = 1'b0;
    end
    for (int r = 0; r < 8; r++) rf_vals[r] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 0, outs0(), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Basic dump with known contents.
    for (int r = 0; r < 8; r++) rf_vals[r] = 16'h1000 + 16'(r);
    pc_val = 16'h3000;
    mem[16'h3000] = 16'h1234; mem[16'h3001] = 16'h5678; mem[16'h3002] = 16'h9ABC;
    do_snap(0, 16'h3000, 16'd3, 1'b1);
    wait_done(0, 200);

    // Backpressure on R3 while the debug data lines toggle.
    rmode[0] = 2; rdy_man[0] = 1'b1;
    rand_mem(16'h0200, 16'd2);
    do_snap(0, 16'h0200, 16'd2, 1'b0);
    n = 0;
    while (!(g_i[0].rf_debug_addr == 3'd3 && !g_i[0].out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    rdy_man[0] = 1'b0;
    n = 0;
    while (!g_i[0].out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!g_i[0].out_valid) fail_now("r3_valid", 0);
    repeat (5) @(posedge clk);
    #2;
    check("r3_held", 0, 64'({g_i[0].out_kind, g_i[0].out_index, g_i[0].out_data}),
          64'({2'd0, 16'd3, 16'h1003}));
    rdy_man[0] = 1'b1;
    wait_done(0, 200);

    // Reset while a memory word is stalled.
    rand_regs();
    rand_mem(16'h0100, 16'd4);
    do_snap(0, 16'h0100, 16'd4, 1'b0);
    n = 0;
    while (!(g_i[0].mem_debug_addr == 16'h0100 && !g_i[0].out_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    rdy_man[0] = 1'b0;
    n = 0;
    while (!(g_i[0].out_valid && g_i[0].out_kind == 2'd2) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(g_i[0].out_valid && g_i[0].out_kind == 2'd2)) fail_now("mem_emit_reached", 0);
    #2;
    rst = 1'b0;
    active[0] = 1'b0;
    exp_q[0].delete();
    #1;
    check("async_reset_outputs", 0, outs0(), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    rdy_man[0] = 1'b1;
    rmode[0] = 1;
    repeat (10) @(posedge clk);
    rand_regs();
    rand_mem(16'h0100, 16'd2);
    do_snap(0, 16'h0100, 16'd2, 1'b0);
    wait_done(0, 300);

    // Address wrap and empty memory section.
    rand_regs();
    rand_mem(16'hFFFE, 16'd3);
    do_snap(0, 16'hFFFE, 16'd3, 1'b0);
    wait_done(0, 300);
    rand_regs();
    do_snap(0, 16'h1234, 16'd0, 1'b0);
    wait_done(0, 300);
    rmode[0] = 0;
    rand_regs();
    do_snap(0, 16'h0000, 16'd0, 1'b1);
    wait_done(0, 300);

    // Latency sweep, free-flowing and with random backpressure.
    for (int i = 1; i < NI; i++) begin
      rmode[i] = 0;
      rand_regs();
      rand_mem(16'h0400, 16'd4);
      do_snap(i, 16'h0400, 16'd4, 1'b1);
      wait_done(i, 400);
      rmode[i] = 1;
      rand_regs();
      rand_mem(16'h7FFD, 16'd5);
      do_snap(i, 16'h7FFD, 16'd5, 1'b0);
      wait_done(i, 600);
    end

    // Start while busy is ignored.
    rmode[0] = 1;
    rand_regs();
    rand_mem(16'h4000, 16'd5);
    rand_mem(16'h5000, 16'd6);
    do_snap(0, 16'h4000, 16'd5, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    mem_base = 16'h5000; mem_count = 16'd6; start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0, 400);
    repeat (30) @(posedge clk);

    // Randomized snapshots across all latencies.
    for (int it = 0; it < 12; it++) begin
      g = it % NI;
      b = 16'($urandom);
      c = 16'($urandom_range(0, 12));
      rmode[g] = int'($urandom_range(0, 1));
      rand_regs();
      rand_mem(b, c);
      do_snap(g, b, c, (rmode[g] == 0));
      wait_done(g, 800);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
